// File: rtl/key_onehot_capture8.sv
// key_onehot_capture8
//
// Input stage ahead of the 8-to-3 binary encoder. Eight raw key lines are
// synchronised, debounced per bit, and each new press event is turned into
// a registered, strictly one-hot code with a single-cycle valid strobe.
// A press event that starts with more than one key is reported on multi_err
// and is never forwarded, so the encoder only ever sees 8'h00 or one bit set.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   keys_raw     raw asynchronous key lines, 1 = pressed
//   onehot       one-hot code of the last accepted press (held after release)
//   valid        1-cycle pulse when onehot is loaded with a new press
//   multi_err    high while the current press event began with several keys
//   keys_stable  debounced key vector (status/debug)
module key_onehot_capture8 #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] keys_raw,
    output logic [7:0] onehot,
    output logic       valid,
    output logic       multi_err,
    output logic [7:0] keys_stable
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchroniser
    // ------------------------------------------------------------------
    logic [7:0] s1_q;
    logic [7:0] s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= keys_raw;
            s2_q <= s1_q;
        end
    end

    // ------------------------------------------------------------------
    // Per-bit debounce: the stable value only flips after the synchronised
    // bit has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
    // Any agreeing cycle restarts the count, so press and release are
    // filtered identically.
    // ------------------------------------------------------------------
    logic [7:0] keys_stable_q;
    logic [7:0] keys_stable_d;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_debounce
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             stable_d;

            always_comb begin
                cnt_d    = cnt_q;
                stable_d = keys_stable_q[gi];
                if (s2_q[gi] == keys_stable_q[gi]) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    stable_d = s2_q[gi];
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign keys_stable_d[gi] = stable_d;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keys_stable_q <= '0;
        end else begin
            keys_stable_q <= keys_stable_d;
        end
    end

    // ------------------------------------------------------------------
    // Press-event FSM. It looks at the registered stable vector, so the
    // decision about a press is made one edge after the debounce flip.
    // ------------------------------------------------------------------
    state_t     state_q;
    state_t     state_d;
    logic [7:0] onehot_q;
    logic [7:0] onehot_d;
    logic       valid_q;
    logic       valid_d;
    logic       multi_err_q;
    logic       multi_err_d;
    logic       any_key;
    logic       single_key;

    assign any_key    = (keys_stable_q != 8'h00);
    // x & (x-1) clears the lowest set bit; zero afterwards means at most one bit.
    assign single_key = any_key && ((keys_stable_q & (keys_stable_q - 8'd1)) == 8'h00);

    always_comb begin
        state_d     = state_q;
        onehot_d    = onehot_q;
        valid_d     = 1'b0;
        multi_err_d = multi_err_q;
        case (state_q)
            IDLE: begin
                if (single_key) begin
                    onehot_d    = keys_stable_q;
                    valid_d     = 1'b1;
                    multi_err_d = 1'b0;
                    state_d     = HELD;
                end else if (any_key) begin
                    // Several keys debounced on the same edge: flag, do not forward.
                    multi_err_d = 1'b1;
                    state_d     = HELD;
                end
            end
            HELD: begin
                // Later keys in the same event are ignored until full release.
                if (!any_key) begin
                    multi_err_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            onehot_q    <= '0;
            valid_q     <= 1'b0;
            multi_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            onehot_q    <= onehot_d;
            valid_q     <= valid_d;
            multi_err_q <= multi_err_d;
        end
    end

    assign onehot      = onehot_q;
    assign valid       = valid_q;
    assign multi_err   = multi_err_q;
    assign keys_stable = keys_stable_q;

endmodule

// File: tb/tb_key_onehot_capture8.sv
// Testbench for key_onehot_capture8 (DEBOUNCE_CYCLES = 4).
// A behavioural model derives the expected outputs from the history of
// sampled raw inputs; a compare process checks every cycle, and directed
// scenarios add hand-computed literal expectations.
module tb_key_onehot_capture8;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] keys_raw = 8'h00;
    logic [7:0] onehot;
    logic       valid;
    logic       multi_err;
    logic [7:0] keys_stable;

    int checks = 0;
    int errors = 0;

    key_onehot_capture8 #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .keys_raw    (keys_raw),
        .onehot      (onehot),
        .valid       (valid),
        .multi_err   (multi_err),
        .keys_stable (keys_stable)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model.
    // hist[0] is the raw vector sampled at the current edge, hist[n] the
    // one sampled n edges earlier. The debounced bit flips when the last
    // DEB synchronised samples (hist[2] .. hist[DEB+1]) all disagree with it.
    // An "event" spans from the first nonzero stable vector to full release.
    // ------------------------------------------------------------------
    logic [7:0] hist [0:DEB+1];
    logic [7:0] m_stable = '0;
    logic [7:0] m_onehot = '0;
    logic       m_valid  = 1'b0;
    logic       m_merr   = 1'b0;
    logic       m_active = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j <= DEB + 1; j++) hist[j] = 8'h00;
            m_stable = '0;
            m_onehot = '0;
            m_valid  = 1'b0;
            m_merr   = 1'b0;
            m_active = 1'b0;
        end else begin
            logic [7:0] old_stable;
            old_stable = m_stable;
            for (int j = DEB + 1; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = keys_raw;

            // Event decisions use the stable vector as it was before this edge.
            m_valid = 1'b0;
            if (!m_active) begin
                if (old_stable != 8'h00) begin
                    m_active = 1'b1;
                    if ($countones(old_stable) == 1) begin
                        m_onehot = old_stable;
                        m_valid  = 1'b1;
                        m_merr   = 1'b0;
                    end else begin
                        m_merr = 1'b1;
                    end
                end
            end else if (old_stable == 8'h00) begin
                m_active = 1'b0;
                m_merr   = 1'b0;
            end

            for (int b = 0; b < 8; b++) begin
                bit all_differ;
                all_differ = 1'b1;
                for (int k = 2; k <= DEB + 1; k++)
                    if (hist[k][b] == old_stable[b]) all_differ = 1'b0;
                if (all_differ) m_stable[b] = ~old_stable[b];
            end
        end
    end

    // Compare process plus protocol invariants, every cycle on the falling edge.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        check("onehot",      onehot,      m_onehot);
        check("valid",       {7'b0, valid},     {7'b0, m_valid});
        check("multi_err",   {7'b0, multi_err}, {7'b0, m_merr});
        check("keys_stable", keys_stable, m_stable);
        check("valid_back_to_back", {7'b0, valid && prev_valid}, 8'h00);
        check("onehot_pow2", {7'b0, (onehot & (onehot - 8'd1)) != 8'h00}, 8'h00);
        prev_valid = valid;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic set_keys(input logic [7:0] v);
        @(negedge clk);
        #2 keys_raw = v;
    endtask

    // Runs n cycles; reports the number of valid pulses and the index of
    // the first falling edge (1-based) on which valid was seen, or -1.
    task automatic run(input int n, output int first, output int cnt);
        first = -1;
        cnt   = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (valid) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
    endtask

    initial begin
        int first;
        int cnt;
        int f2;
        int c2;

        // Reset then idle
        repeat (3) @(negedge clk);
        check("reset_onehot", onehot, 8'h00);
        check("reset_stable", keys_stable, 8'h00);
        #2 rst_n = 1'b1;
        run(20, first, cnt);
        $display("idle: valids=%0d onehot=%h", cnt, onehot);
        check("idle_valid_count", 8'(cnt), 8'd0);
        check("idle_onehot", onehot, 8'h00);

        // Single press; first valid seen 7 falling edges after the change,
        // i.e. during the cycle after edge E+6.
        set_keys(8'h10);
        run(20, first, cnt);
        $display("press 10: first=%0d valids=%0d onehot=%h", first, cnt, onehot);
        check("single_latency", 8'(first), 8'd7);
        check("single_count", 8'(cnt), 8'd1);
        check("single_onehot", onehot, 8'h10);
        set_keys(8'h00);
        run(15, first, cnt);
        $display("release: valids=%0d onehot=%h", cnt, onehot);
        check("release_count", 8'(cnt), 8'd0);
        check("release_hold", onehot, 8'h10);

        // Bounce: 3 cycles high, 2 low, then steady
        set_keys(8'h04);
        run(2, first, cnt);
        set_keys(8'h00);
        run(1, f2, c2);
        cnt += c2;
        set_keys(8'h04);
        run(20, first, c2);
        cnt += c2;
        $display("bounce 04: first=%0d valids=%0d onehot=%h", first, cnt, onehot);
        check("bounce_count", 8'(cnt), 8'd1);
        check("bounce_latency", 8'(first), 8'd7);
        check("bounce_onehot", onehot, 8'h04);
        set_keys(8'h00);
        run(15, first, cnt);

        // 3-cycle glitch only
        set_keys(8'h40);
        run(2, first, cnt);
        set_keys(8'h00);
        run(15, first, c2);
        cnt += c2;
        $display("glitch 40: valids=%0d onehot=%h stable=%h", cnt, onehot, keys_stable);
        check("glitch_count", 8'(cnt), 8'd0);
        check("glitch_onehot", onehot, 8'h04);

        // Simultaneous press
        set_keys(8'h81);
        run(12, first, cnt);
        $display("press 81: valids=%0d multi_err=%0b onehot=%h", cnt, multi_err, onehot);
        check("multi_count", 8'(cnt), 8'd0);
        check("multi_err_set", {7'b0, multi_err}, 8'h01);
        check("multi_onehot", onehot, 8'h04);
        set_keys(8'h00);
        run(12, first, cnt);
        $display("release 81: multi_err=%0b", multi_err);
        check("multi_err_clear", {7'b0, multi_err}, 8'h00);
        set_keys(8'h02);
        run(12, first, cnt);
        $display("press 02: valids=%0d onehot=%h", cnt, onehot);
        check("after_multi_count", 8'(cnt), 8'd1);
        check("after_multi_onehot", onehot, 8'h02);
        set_keys(8'h00);
        run(12, first, cnt);

        // Staggered press: 01, then 08 added two cycles later
        set_keys(8'h01);
        run(1, first, cnt);
        set_keys(8'h09);
        run(15, f2, c2);
        cnt += c2;
        $display("stagger 01+08: valids=%0d onehot=%h multi_err=%0b", cnt, onehot, multi_err);
        check("stagger_count", 8'(cnt), 8'd1);
        check("stagger_onehot", onehot, 8'h01);
        check("stagger_merr", {7'b0, multi_err}, 8'h00);
        set_keys(8'h00);
        run(12, first, cnt);
        set_keys(8'h08);
        run(12, first, cnt);
        $display("press 08: valids=%0d onehot=%h", cnt, onehot);
        check("second_count", 8'(cnt), 8'd1);
        check("second_onehot", onehot, 8'h08);
        set_keys(8'h00);
        run(12, first, cnt);

        // Reset mid-event
        set_keys(8'h20);
        run(12, first, cnt);
        check("pre_reset_onehot", onehot, 8'h20);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        $display("async reset: onehot=%h stable=%h valid=%0b merr=%0b", onehot, keys_stable, valid, multi_err);
        check("rst_onehot", onehot, 8'h00);
        check("rst_stable", keys_stable, 8'h00);
        check("rst_merr", {7'b0, multi_err}, 8'h00);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        run(20, first, cnt);
        $display("after reset: first=%0d valids=%0d onehot=%h", first, cnt, onehot);
        check("rst_latency", 8'(first), 8'd7);
        check("rst_count", 8'(cnt), 8'd1);
        check("rst_reonehot", onehot, 8'h20);
        set_keys(8'h00);
        run(12, first, cnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
